// File: rtl/emb_seq_if.sv
// Signal bundle between the sequence controller and its environment:
// the sequence request/result side plus the shared embedding-block lookup side.
interface emb_seq_if #(
    parameter int N        = 10,
    parameter int CHAR_LEN = 8,
    parameter int EMB_DIM  = 24,
    parameter int N_LEN    = 16
) ();
    logic                          run;
    logic [N*CHAR_LEN-1:0]         d;
    logic                          valid;
    logic                          busy;
    logic [N*EMB_DIM*N_LEN-1:0]    q;
    logic                          blk_run;
    logic [CHAR_LEN-1:0]           blk_d;
    logic                          blk_valid;
    logic [EMB_DIM*N_LEN-1:0]      blk_q;

    // Handshake: run is a request taken only in IDLE/DONE, valid is a level held until the
    // next accepted run; blk_run is a one-cycle lookup pulse, blk_valid answers it and is only
    // consumed while the controller waits, so a stray or late blk_valid is simply dropped.
    modport master (
        input  run, d, blk_valid, blk_q,
        output valid, busy, q, blk_run, blk_d
    );
    modport slave (
        output run, d, blk_valid, blk_q,
        input  valid, busy, q, blk_run, blk_d
    );
endinterface

// File: rtl/emb_seq_ctrl.sv
// Serialises N character-embedding lookups through one shared embedding block and
// assembles the per-character results into one wide output vector.
module emb_seq_ctrl #(
    parameter int N        = 10,
    parameter int CHAR_LEN = 8,
    parameter int EMB_DIM  = 24,
    parameter int N_LEN    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    emb_seq_if.master                        bus,
    // State encoding: 0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE
    output logic [1:0]                       dbg_state,
    output logic [$clog2(N > 1 ? N : 2)-1:0] dbg_idx
);
    localparam int IDX_W  = $clog2(N > 1 ? N : 2);
    localparam int SLOT_W = EMB_DIM * N_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N*CHAR_LEN-1:0] code_q, code_d;
    logic [N*SLOT_W-1:0]   q_q, q_d;
    logic [CHAR_LEN-1:0]   cur_code;
    logic                  last;

    assign cur_code = code_q[int'(idx_q)*CHAR_LEN +: CHAR_LEN];
    assign last     = (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        code_d      = code_q;
        q_d         = q_q;
        bus.blk_run = 1'b0;
        bus.blk_d   = '0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.run) begin
                    code_d  = bus.d;
                    q_d     = '0;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.blk_d = cur_code;
                // A zero code is padding: its slot stays zero and costs a single cycle.
                if (cur_code != '0) begin
                    bus.blk_run = 1'b1;
                    state_d     = WAIT;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WAIT: begin
                bus.blk_d = cur_code;
                if (bus.blk_valid) begin
                    q_d[int'(idx_q)*SLOT_W +: SLOT_W] = bus.blk_q;
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            q_q     <= q_d;
        end
    end

    assign bus.valid = (state_q == DONE);
    assign bus.busy  = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.q     = q_q;
    assign dbg_state = state_q;
    assign dbg_idx   = idx_q;
endmodule

// File: tb/tb_emb_seq_ctrl.sv
// Directed bench for emb_seq_ctrl: a timeline model of the lookup schedule predicts every
// output each cycle, while a latency-programmable responder stands in for the embedding block.
module tb_emb_seq_ctrl;
    localparam int N     = 10;
    localparam int CL    = 8;
    localparam int ED    = 24;
    localparam int NL    = 16;
    localparam int SW    = ED * NL;
    localparam int NEVER = 1 << 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] dbg_state;
    logic [3:0] dbg_idx;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    emb_seq_if #(.N(N), .CHAR_LEN(CL), .EMB_DIM(ED), .N_LEN(NL)) bus ();

    emb_seq_ctrl #(.N(N), .CHAR_LEN(CL), .EMB_DIM(ED), .N_LEN(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_idx   (dbg_idx)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state ----------------
    logic [CL-1:0] s_codes[N];
    int            s_lats[N];
    logic [CL-1:0] m_code[N];
    int            m_run[N];
    int            m_resp[N];
    int            m_done;
    int            m_rst = NEVER;
    int            base = 0;
    bit            chk_en = 1'b0;
    logic [CL-1:0] exp_q[$];

    int            r_lat[N];
    int            r_j = 0;
    int            r_pend = 0;
    logic [CL-1:0] r_code = '0;

    int            obs_runs;
    int            obs_first_run;
    int            obs_last_run;
    int            obs_first_valid;

    function automatic logic [SW-1:0] emb(input logic [CL-1:0] c);
        logic [SW-1:0] v;
        v = '0;
        for (int e = 0; e < ED; e++)
            v[e*NL +: NL] = (16'(c) * 16'd97 + 16'(e) * 16'd131) ^ 16'hA5C3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Pulses run with s_codes, then builds the schedule: each non-zero code costs its
    // latency plus one cycle, each padding code costs one cycle, valid follows the last.
    task automatic start_seq();
        int t;
        int j;
        for (int k = 0; k < N; k++) bus.d[k*CL +: CL] = s_codes[k];
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        for (int k = 0; k < N; k++) bus.d[k*CL +: CL] = 8'($urandom_range(0, 255));
        base = cyc - 1;
        t = 1;
        j = 0;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            m_code[k] = s_codes[k];
            if (s_codes[k] != '0) begin
                m_run[k]  = t;
                m_resp[k] = t + s_lats[j];
                t         = m_resp[k] + 1;
                exp_q.push_back(s_codes[k]);
                j++;
            end else begin
                m_run[k]  = -1;
                m_resp[k] = -1;
                t         = t + 1;
            end
        end
        m_done = t;
        m_rst  = NEVER;
        for (int k = 0; k < N; k++) r_lat[k] = s_lats[k];
        r_j             = 0;
        obs_runs        = 0;
        obs_first_run   = -1;
        obs_last_run    = -1;
        obs_first_valid = -1;
        chk_en          = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (obs_first_valid < 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (obs_first_valid < 0) chk("valid_timeout", 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- embedding block stand-in ----------------
    initial begin
        bus.blk_valid = 1'b0;
        bus.blk_q     = '0;
        forever begin
            @(posedge clk); #2;
            bus.blk_valid = 1'b0;
            bus.blk_q     = {12{$urandom()}};
            if (r_pend > 0) begin
                r_pend--;
                if (r_pend == 0) begin
                    bus.blk_valid = 1'b1;
                    bus.blk_q     = emb(r_code);
                end
            end
            if (bus.blk_run === 1'b1) begin
                r_pend = r_lat[r_j];
                r_code = bus.blk_d;
                if (r_j < N - 1) r_j++;
            end
        end
    end

    // ---------------- scoreboard / per-cycle compare ----------------
    initial begin
        int            r;
        logic          e_run;
        logic [CL-1:0] e_bd;
        logic          e_busy;
        logic          e_valid;
        logic [SW-1:0] e_slot;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                r     = cyc - base;
                e_run = 1'b0;
                e_bd  = '0;
                for (int k = 0; k < N; k++) begin
                    if (m_run[k] == r) e_run = 1'b1;
                    if (m_run[k] >= 0 && r >= m_run[k] && r <= m_resp[k]) e_bd = m_code[k];
                end
                e_busy  = (r >= 1) && (r < m_done);
                e_valid = (r >= m_done);
                if (r >= m_rst) begin
                    e_run   = 1'b0;
                    e_bd    = '0;
                    e_busy  = 1'b0;
                    e_valid = 1'b0;
                end
                chk("blk_run", bus.blk_run, e_run);
                chk("blk_d", bus.blk_d, e_bd);
                chk("busy", bus.busy, e_busy);
                chk("valid", bus.valid, e_valid);
                for (int k = 0; k < N; k++) begin
                    e_slot = (m_run[k] >= 0 && r > m_resp[k] && r < m_rst) ? emb(m_code[k]) : '0;
                    chk($sformatf("q_slot%0d", k), bus.q[k*SW +: SW], e_slot);
                end
                if (bus.blk_run === 1'b1) begin
                    obs_runs++;
                    if (obs_first_run < 0) obs_first_run = r;
                    obs_last_run = r;
                    if (exp_q.size() == 0) chk("sb_extra_run", 1'b1, 1'b0);
                    else chk("sb_blk_d", bus.blk_d, exp_q.pop_front());
                end
                if (bus.valid === 1'b1 && obs_first_valid < 0) obs_first_valid = r;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        bus.run = 1'b0;
        bus.d   = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_blk_run", bus.blk_run, 1'b0);
        chk("rst_blk_d", bus.blk_d, '0);
        chk("rst_q_or", |bus.q, 1'b0);
        chk("rst_state", dbg_state, 2'd0);

        // full sequence, run offered in the very cycle reset is released
        rst = 1'b0;
        s_codes = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        s_lats  = '{default: 2};
        start_seq();
        wait_valid(200);
        chk("full_valid_cycle", obs_first_valid, 31);
        chk("full_run_count", obs_runs, 10);
        chk("full_first_run", obs_first_run, 1);
        chk("full_last_run", obs_last_run, 28);
        chk("full_sb_empty", exp_q.size(), 0);

        // padding, issued back-to-back from DONE
        s_codes = '{8'd5, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        start_seq();
        wait_valid(200);
        chk("pad_valid_cycle", obs_first_valid, 15);
        chk("pad_run_count", obs_runs, 2);
        chk("pad_slot3", bus.q[3*SW +: SW], emb(8'd7));

        // run while busy: a second request with other codes at cycle 5 is ignored
        s_codes = '{8'd9, 8'd8, 8'd0, 8'd6, 8'd5, 8'd4, 8'd0, 8'd2, 8'd1, 8'd3};
        s_lats  = '{default: 3};
        start_seq();
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) bus.d[k*CL +: CL] = 8'(8'd100 + k);
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        wait_valid(200);
        chk("busy_valid_cycle", obs_first_valid, 35);
        chk("busy_run_count", obs_runs, 8);

        // variable latency per lookup
        s_codes = '{8'd0, 8'd17, 8'd200, 8'd0, 8'd33, 8'd255, 8'd1, 8'd0, 8'd0, 8'd64};
        for (int k = 0; k < N; k++) s_lats[k] = $urandom_range(1, 8);
        start_seq();
        wait_valid(300);
        chk("varlat_run_count", obs_runs, 6);
        chk("varlat_sb_empty", exp_q.size(), 0);

        // reset mid-WAIT, with the block answering the dead request at cycle 8
        s_codes = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        s_lats  = '{default: 2};
        s_lats[1] = 4;
        start_seq();
        repeat (5) @(posedge clk);
        #1;
        m_rst = 6;
        rst   = 1'b1;
        #1;
        chk("midrst_state", dbg_state, 2'd0);
        chk("midrst_idx", dbg_idx, 4'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("post_stray_state", dbg_state, 2'd0);
        chk("post_stray_runs", obs_runs, 2);

        // recovery with single-cycle latency
        s_lats = '{default: 1};
        start_seq();
        wait_valid(200);
        chk("recover_valid_cycle", obs_first_valid, 21);
        chk("recover_run_count", obs_runs, 10);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/emb_seq_ctrl.md
EMB_SEQ_CTRL -- requirements
Module: emb_seq_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter N, 10: characters per sequence.
REQ-002 SHALL have parameter CHAR_LEN, 8: character code width.
REQ-003 SHALL have parameter EMB_DIM, 24: embedding elements per character.
REQ-004 SHALL have parameter N_LEN, 16: element width in bits.

Ports:
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port run, input, 1: start request, sampled in IDLE or DONE only.
REQ-009 SHALL have port d, input, N*CHAR_LEN: character codes, char i at d[i*CHAR_LEN +: CHAR_LEN].
REQ-010 SHALL have port valid, output, 1: result complete, held high in DONE.
REQ-011 SHALL have port busy, output, 1: high in ISSUE or WAIT.
REQ-012 SHALL have port q, output, N*EMB_DIM*N_LEN: embeddings, char i at q[i*EMB_DIM*N_LEN +: EMB_DIM*N_LEN].
REQ-013 SHALL have port blk_run, output, 1: one-cycle lookup request to the shared embedding block.
REQ-014 SHALL have port blk_d, output, CHAR_LEN: code for the current lookup.
REQ-015 SHALL have port blk_valid, input, 1: lookup result ready.
REQ-016 SHALL have port blk_q, input, EMB_DIM*N_LEN: lookup result.

Function
REQ-017 SHALL serialize N lookups through one shared embedding block, replacing N parallel blocks.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-019 SHALL, on run=1 in IDLE or DONE:
- latch d into an internal buffer
- clear q to all-zero
- set index idx=0
- drop valid
- enter ISSUE on the next cycle.
REQ-020 SHALL ignore run in ISSUE and WAIT; d changes after acceptance SHALL NOT affect the result.
REQ-021 SHALL, in ISSUE with code[idx]!=0: assert blk_run for exactly that cycle, drive blk_d=code[idx], and go to WAIT.
REQ-022 SHALL treat code[idx]==0 as padding in ISSUE:
- no blk_run is issued
- slot idx stays zero
- advance idx, or go to DONE if idx==N-1, in one cycle.
REQ-023 SHALL, in WAIT with blk_valid=1: write blk_q into q slot idx on that edge, then go to DONE if idx==N-1, else increment idx and return to ISSUE.
REQ-024 SHALL ignore blk_valid outside WAIT; WAIT has no timeout.
REQ-025 SHALL hold blk_d stable at code[idx] from ISSUE through WAIT, and drive blk_d=0 otherwise.
REQ-026 SHALL assert valid=1 in DONE and hold valid and q unchanged until the next accepted run.
REQ-027 SHALL hold q stable except at slot writes and the clear on run acceptance.
REQ-028 SHALL meet this timing for block latency L (blk_run cycle to blk_valid cycle, L>=1), run accepted at cycle 0, all codes non-zero:
- char k blk_run at cycle 1+k*(L+1)
- valid first high at cycle N*(L+1)+1.
REQ-029 SHALL spend exactly 1 cycle per padding character.
REQ-030 SHALL, on run in DONE, drop valid on the following cycle and start the new sequence with no IDLE cycle.
REQ-031 SHALL hold idx width ceil(log2 N) and never let idx exceed N-1.

Reset
REQ-032 SHALL, on rst=1 at any time, including mid-sequence, immediately force:
- state=IDLE, idx=0
- valid=0, busy=0, blk_run=0, blk_d=0
- q=0 and the latched d=0.
REQ-033 SHALL ignore a blk_valid that arrives after reset release for a request issued before reset.
REQ-034 SHALL accept run on the first clock edge after rst deasserts.

Verification
REQ-035 SHALL pass scenario "full sequence": d codes 1..10, model L=2, run pulse at cycle 0 -> blk_run at cycles 1,4,...,28; valid high at cycle 31; slot i = model(i+1).
REQ-036 SHALL pass scenario "padding": codes {5,0,0,7,0,0,0,0,0,0}, L=2 -> only 2 blk_run pulses; slots 1,2,4-9 zero; valid at cycle 15.
REQ-037 SHALL pass scenario "run while busy": run re-pulsed with different d at cycle 5 -> ignored; result matches the first d.
REQ-038 SHALL pass scenario "back-to-back": run asserted in DONE -> valid low next cycle, q cleared, second result correct.
REQ-039 SHALL pass scenario "reset mid-WAIT": rst at cycle 6, then a stray blk_valid at cycle 8 -> all outputs 0, FSM IDLE, stray ignored.
REQ-040 SHALL pass scenario "variable latency": L randomized 1..8 per lookup -> blk_run count equals the non-zero code count; q bit-exact versus the model.
